// File: rtl/ksa8_slice_seq.sv
// ----------------------------------------------------------------------------
// ksa8_slice_seq
//
// Performs a WIDTH-bit addition (WIDTH = 8*NSLICE) one byte per cycle around
// an external, purely combinational 8-bit prefix adder that has no carry-in.
// This block sends one byte-slice of each operand to the adder every cycle.
// It adds the inter-slice carry to the returned sum and assembles the wide
// result. Operands arrive through a valid/ready handshake, and results leave
// through a second valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair offered
//   in_ready   block can accept operands (IDLE only)
//   in_a/in_b  WIDTH-bit operands
//   add_a/b    byte-slice driven to the 8-bit adder (0 outside RUN)
//   add_sum    adder sum of add_a+add_b, same cycle
//   add_cout   adder carry-out, same cycle
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   out_sum    (in_a+in_b) mod 2^WIDTH
//   out_cout   carry out of bit WIDTH-1
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands; in_ready=1, adder inputs held at 0
// RUN   | one slice per cycle from the shift registers, carry folded in
// DONE  | result presented with out_valid=1 until out_ready is seen
// ----------------------------------------------------------------------------
module ksa8_slice_seq #(
   parameter int NSLICE = 4,
   localparam int WIDTH = 8 * NSLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [7:0]       add_a,
   output logic [7:0]       add_b,
   input  logic [7:0]       add_sum,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // The index is 4 bits wide because NSLICE is at most 16.
   localparam logic [3:0] LAST_IDX = 4'(NSLICE - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [3:0]       idx_q, idx_d;
   logic             cy_q, cy_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic [7:0]       slice;
   logic             cy_next;

   // The adder has no carry input, so the incoming carry is added here.
   // The increment can only carry out of the byte when add_sum is 0xFF.
   // In that case the carry passes through even when add_cout is 0.
   assign slice   = add_sum + {7'd0, cy_q};
   assign cy_next = add_cout | ((&add_sum) & cy_q);

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      cy_d    = cy_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               idx_d   = 4'd0;
               cy_d    = 1'b0;
               res_d   = '0;
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            for (int s = 0; s < NSLICE; s++) begin
               if (idx_q == 4'(s)) begin
                  res_d[8*s +: 8] = slice;
               end
            end
            a_d   = a_q >> 8;
            b_d   = b_q >> 8;
            idx_d = idx_q + 4'd1;
            cy_d  = cy_next;
            if (idx_q == LAST_IDX) begin
               // The output registers are separate from the working
               // result. This keeps out_sum stable after the handshake
               // while the next operation clears and rebuilds res_q.
               sum_d   = res_d;
               cout_d  = cy_next;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= 4'd0;
         cy_q    <= 1'b0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         cy_q    <= cy_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   // Reset is synchronous, so a state register can still hold RUN or DONE
   // while rst_n is low. Gating the outputs with rst_n forces them to 0
   // for the whole reset.
   assign in_ready  = rst_n & (state_q == ST_IDLE);
   assign out_valid = rst_n & (state_q == ST_DONE);
   assign out_sum   = rst_n ? sum_q : '0;
   assign out_cout  = rst_n & cout_q;
   assign add_a     = (rst_n && (state_q == ST_RUN)) ? a_q[7:0] : 8'd0;
   assign add_b     = (rst_n && (state_q == ST_RUN)) ? b_q[7:0] : 8'd0;

endmodule

// File: tb/tb_ksa8_slice_seq.sv
module tb_ksa8_slice_seq;

   localparam int NSLICE = 4;
   localparam int WIDTH  = 8 * NSLICE;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [7:0]       add_a;
   logic [7:0]       add_b;
   logic [7:0]       add_sum;
   logic             add_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   always #5 clk = ~clk;

   // 8-bit adder with no carry-in, placed between add_a/b and add_sum/cout.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

   ksa8_slice_seq #(.NSLICE(NSLICE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout)
   );

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      int               acc_edge;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Out_ready driver, updated just after each rising edge.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Reference model: on every accepted operand pair, push the full-width
   // sum with carry out. An input is accepted when in_valid and in_ready
   // are both high ahead of the next rising edge.
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) begin
         logic [WIDTH:0] full;
         exp_t e;
         full       = {1'b0, in_a} + {1'b0, in_b};
         e.sum      = full[WIDTH-1:0];
         e.cout     = full[WIDTH];
         e.acc_edge = cyc + 1;
         exp_q.push_back(e);
      end
   end

   // Monitor: checks the reset values, first-valid latency, stability
   // under backpressure, and the result on every output handshake.
   logic             prev_valid = 1'b0;
   logic             prev_ready = 1'b0;
   logic [WIDTH-1:0] prev_sum   = '0;
   logic             prev_cout  = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_outputs",
             {38'd0, in_ready, out_valid, out_cout, add_a, add_b, out_sum[7:0]},
             64'd0);
         chk("reset_out_sum", {32'd0, out_sum}, 64'd0);
         prev_valid = 1'b0;
         prev_ready = 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
               chk("latency", 64'(cyc - exp_q[0].acc_edge), 64'(NSLICE));
            end
         end
         if (out_valid && prev_valid && !prev_ready) begin
            chk("stable_sum", {32'd0, out_sum}, {32'd0, prev_sum});
            chk("stable_cout", {63'd0, out_cout}, {63'd0, prev_cout});
         end
         if (out_valid) begin
            chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
         end
         if (out_valid && out_ready && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("out_sum", {32'd0, out_sum}, {32'd0, e.sum});
            chk("out_cout", {63'd0, out_cout}, {63'd0, e.cout});
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_sum   = out_sum;
         prev_cout  = out_cout;
      end
   end

   // Drive one operand pair and wait, with a bound, until it is accepted.
   // The task returns just after the accept edge. If keep=1, in_valid
   // stays high.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit keep, output int acc);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      acc      = -1;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = cyc + 1;
            break;
         end
      end
      if (acc < 0) chk("accept_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || out_valid) && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int acc;
      int prev_acc;
      logic [WIDTH-1:0] b2b_a[5];
      logic [WIDTH-1:0] b2b_b[5];

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
      chk("idle_add_ab", {48'd0, add_a, add_b}, 64'd0);

      // Directed sums: a plain case, a full carry ripple, and the FF+cy path.
      rdy_mode = 1;
      issue(32'h12345678, 32'h9ABCDEF0, 1'b0, acc);
      wait_idle();
      issue(32'hFFFFFFFF, 32'h00000001, 1'b0, acc);
      wait_idle();
      issue(32'h0000FF80, 32'h00000080, 1'b0, acc);
      wait_idle();

      // Backpressure: out_ready is held low for 6 cycles after out_valid
      // rises, and an in_valid pulse during that time must be ignored.
      @(posedge clk); #1 rdy_mode = 0; out_ready = 1'b0;
      issue(32'hDEADBEEF, 32'h01020304, 1'b0, acc);
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      chk("bp_valid_seen", {63'd0, out_valid}, 64'd1);
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         in_valid = (k == 2);
         in_a     = 32'h11111111;
         in_b     = 32'h22222222;
         @(negedge clk);
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
         chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rdy_mode = 1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
      chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);

      // Reset mid-RUN, with idx at 2: the aborted operation must produce
      // no result.
      issue(32'hCAFEF00D, 32'h0BADBEEF, 1'b0, acc);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
      chk("post_reset_out_valid", {63'd0, out_valid}, 64'd0);
      repeat (8) @(negedge clk);
      issue(32'h00000001, 32'h00000002, 1'b0, acc);
      wait_idle();

      // Back-to-back: in_valid stays high and accepts must be 6 cycles apart.
      b2b_a[0] = 32'h80000000; b2b_b[0] = 32'h80000000;
      b2b_a[1] = 32'h00FF00FF; b2b_b[1] = 32'h00010001;
      b2b_a[2] = 32'hFFFF0000; b2b_b[2] = 32'h0000FFFF;
      b2b_a[3] = $urandom;     b2b_b[3] = $urandom;
      b2b_a[4] = 32'hFFFFFFFF; b2b_b[4] = 32'hFFFFFFFF;
      prev_acc = -1;
      for (int i = 0; i < 5; i++) begin
         issue(b2b_a[i], b2b_b[i], 1'b1, acc);
         if (prev_acc >= 0) chk("b2b_spacing", 64'(acc - prev_acc), 64'(NSLICE + 2));
         prev_acc = acc;
      end
      in_valid = 1'b0;
      wait_idle();

      // Random operands with random out_ready and random gaps between them.
      // Some operands are biased toward long carry chains.
      rdy_mode = 2;
      for (int i = 0; i < 30; i++) begin
         logic [WIDTH-1:0] a, b;
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 3))
            0: b = ~a;
            1: b = ~a + 32'(($urandom_range(0, 1)));
            default: ;
         endcase
         issue(a, b, 1'b0, acc);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
      end
      rdy_mode = 1;
      wait_idle();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

endmodule
